seq_divider_16bit: RTL and testbench

SEQ_DIVIDER_16BIT -- requirements
Module: seq_divider_16bit

---
 rtl/seq_divider_16bit.sv | 136 +++++++++++++
 tb/tb_seq_divider_16bit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: 16-bit unsigned restoring divider, one quotient bit per
// RUN cycle (MSB first). A start is accepted in IDLE or DONE; the operands are
// latched on that edge and the divide begins on the following edge, so a
// non-zero divide completes 17 cycles after acceptance and a divide by zero
// completes after 1 cycle. The quotient/remainder outputs are only written on
// completion, so intermediate values never appear on the ports.
module seq_divider_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        go_q, go_d;        // operands latched, divide begins next edge
    logic [15:0] dvd_q, dvd_d;      // dividend shifting out MSB first, quotient shifting in
    logic [15:0] dsr_q, dsr_d;      // latched divisor
    logic [15:0] rem_q, rem_d;      // partial remainder
    logic [3:0]  cnt_q, cnt_d;      // iteration counter
    logic [15:0] quo_q, quo_d;
    logic [15:0] rmd_q, rmd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic [16:0] shifted;
    logic [16:0] diff;

    // Next-state, datapath iteration and registered-output computation
    always_comb begin
        state_d = state_q;
        go_d    = go_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        // 17-bit shift-in of the next dividend bit and trial subtract
        shifted = {rem_q, dvd_q[15]};
        diff    = shifted - {1'b0, dsr_q};

        case (state_q)
            RUN: begin
                // Restored remainder always fits 16 bits since it is below the divisor
                rem_d = diff[16] ? shifted[15:0] : diff[15:0];
                dvd_d = {dvd_q[14:0], ~diff[16]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = dvd_d;
                    rmd_d   = rem_d;
                end
            end
            default: begin
                if (go_q) begin
                    go_d = 1'b0;
                    if (dsr_q == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = dvd_q;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end else if (start) begin
                    go_d    = 1'b1;
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State machine and registered outputs, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Testbench for seq_divider_16bit: directed vector table, hand-written
// multi-cycle sequences and a randomized sweep against an arithmetic model.
module tb_seq_divider_16bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider_16bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Present a request now; it is accepted on the next rising edge
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_low_after_accept", 32'(done), 32'd0);
    endtask

    // Count edges from acceptance until done, with a bounded budget
    task automatic wait_done(output int lat, output int busy_cnt);
        logic seen;
        lat = 0;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    // Arithmetic reference: plain division, fixed divide-by-zero convention
    task automatic check_model(input logic [15:0] a, input logic [15:0] b,
                               input int lat, input int busy_cnt);
        int unsigned eq, er, elat, ebusy;
        logic edbz;
        if (b == 16'd0) begin
            eq = 32'hFFFF; er = a; edbz = 1'b1; elat = 1; ebusy = 0;
        end else begin
            eq = a / b; er = a % b; edbz = 1'b0; elat = 17; ebusy = 16;
        end
        chk("rand_quotient", 32'(quotient), eq);
        chk("rand_remainder", 32'(remainder), er);
        chk("rand_dbz", 32'(div_by_zero), 32'(edbz));
        chk("rand_latency", lat, elat);
        chk("rand_busy_cycles", busy_cnt, ebusy);
        if (b != 16'd0) begin
            chk("rand_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk("rand_rem_lt_div", 32'(remainder < b), 32'd1);
        end
    endtask

    initial begin
        int lat, bcnt, done_cnt;
        logic [15:0] ra, rb;
        logic seen;

        vecs[0] = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 17};
        vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0, 17};
        vecs[2] = '{16'h8000,  16'hFFFF,   16'd0,      16'h8000,   1'b0, 17};
        vecs[3] = '{16'd5,     16'd0,      16'hFFFF,   16'd5,      1'b1, 1};
        vecs[4] = '{16'd9,     16'd3,      16'd3,      16'd0,      1'b0, 17};
        vecs[5] = '{16'd1000,  16'd3,      16'd333,    16'd1,      1'b0, 17};
        vecs[6] = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0, 17};
        vecs[7] = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0, 17};
        vecs[8] = '{16'd1,     16'd2,      16'd0,      16'd1,      1'b0, 17};
        vecs[9] = '{16'd3,     16'd10,     16'd0,      16'd3,      1'b0, 17};

        // Reset state
        #12;
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table, each operation started from IDLE
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            chk("vec_quotient", 32'(quotient), 32'(vecs[i].q));
            chk("vec_remainder", 32'(remainder), 32'(vecs[i].r));
            chk("vec_dbz", 32'(div_by_zero), 32'(vecs[i].dbz));
            chk("vec_latency", lat, vecs[i].lat);
            @(posedge clk); #1;
            chk("vec_done_one_cycle", 32'(done), 32'd0);
            chk("vec_result_held", 32'({quotient, remainder}), {vecs[i].q, vecs[i].r});
        end

        // Back-to-back: second start presented during the DONE cycle
        launch(16'hFFFF, 16'd1);
        wait_done(lat, bcnt);
        chk("b2b_first_quotient", 32'(quotient), 32'hFFFF);
        chk("b2b_first_remainder", 32'(remainder), 32'd0);
        launch(16'h8000, 16'hFFFF);
        chk("b2b_held_during_pending", 32'(quotient), 32'hFFFF);
        wait_done(lat, bcnt);
        chk("b2b_second_quotient", 32'(quotient), 32'd0);
        chk("b2b_second_remainder", 32'(remainder), 32'h8000);
        chk("b2b_second_latency", lat, 17);

        // Start pulsed during RUN must be ignored
        @(posedge clk); #1;
        launch(16'd3, 16'd10);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin
                start = 1'b1; dividend = 16'd50; divisor = 16'd5;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("ignore_done_seen", 32'(seen), 32'd1);
        chk("ignore_latency", lat, 17);
        chk("ignore_quotient", 32'(quotient), 32'd0);
        chk("ignore_remainder", 32'(remainder), 32'd3);
        @(posedge clk); #1;
        chk("ignore_no_second_done", 32'(done), 32'd0);

        // Reset in the middle of RUN: asynchronous clear, no done afterwards
        launch(16'd1000, 16'd3);
        repeat (8) @(posedge clk);
        #1;
        chk("mid_run_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_quotient", 32'(quotient), 32'd0);
        chk("async_rst_remainder", 32'(remainder), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        chk("no_done_after_rst", done_cnt, 0);

        // Start on the first edge after reset release
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        launch(16'd1000, 16'd3);
        wait_done(lat, bcnt);
        chk("post_rst_quotient", 32'(quotient), 32'd333);
        chk("post_rst_remainder", 32'(remainder), 32'd1);
        chk("post_rst_latency", lat, 17);
        chk("post_rst_busy_cycles", bcnt, 16);

        // Randomized back-to-back sweep against the arithmetic model
        for (int n = 0; n < 3000; n++) begin
            int unsigned sel;
            sel = $urandom_range(0, 15);
            ra = 16'($urandom);
            if (sel == 0) rb = 16'd0;
            else if (sel < 5) rb = 16'($urandom_range(1, 15));
            else rb = 16'($urandom);
            if (sel == 15) ra = 16'hFFFF;
            launch(ra, rb);
            wait_done(lat, bcnt);
            check_model(ra, rb, lat, bcnt);
        end
        @(posedge clk); #1;
        chk("final_done_one_cycle", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
